// File: rtl/xbar_pkg.sv
// Shared crossbar definitions: opcodes, field widths, bank-select mapping
// and the request payload held in each bank's output register.
package xbar_pkg;

    localparam int unsigned ADDR_W    = 28;
    localparam int unsigned CH_ID_W   = 2;
    localparam int unsigned WBUF_ID_W = 8;
    localparam int unsigned OP_W      = 2;
    localparam int unsigned NUM_BANK  = 4;
    localparam int unsigned BANK_W    = 2;

    // Bank select is byte-address bits [5:4]; channel addresses start at byte bit 4.
    localparam int unsigned BANK_SEL_MSB = 5;
    localparam int unsigned BANK_SEL_LSB = 4;
    localparam int unsigned LINE_LSB     = 4;

    typedef enum logic [OP_W-1:0] {
        OP_READ  = 2'b00,
        OP_WRITE = 2'b01,
        OP_FLUSH = 2'b10,
        OP_RSVD  = 2'b11
    } op_e;

    typedef struct packed {
        logic [CH_ID_W-1:0]   ch_id;
        logic [OP_W-1:0]      op;
        logic [ADDR_W-1:0]    addr;
        logic [WBUF_ID_W-1:0] wbuf_id;
    } htu_req_t;

    function automatic logic [BANK_W-1:0] bank_of(input logic [ADDR_W-1:0] line_addr);
        return line_addr[BANK_SEL_MSB-LINE_LSB : BANK_SEL_LSB-LINE_LSB];
    endfunction

endpackage

// File: rtl/rr_arb3.sv
// Three-way round-robin picker: first requester at ptr, ptr+1, ptr+2 (mod 3).
module rr_arb3 (
    input  logic [2:0] req_i,
    input  logic [1:0] ptr_i,
    output logic [2:0] gnt_onehot_o,
    output logic [1:0] gnt_id_o
);

    logic [1:0] ord [3];

    always_comb begin
        case (ptr_i)
            2'd1:    ord = '{2'd1, 2'd2, 2'd0};
            2'd2:    ord = '{2'd2, 2'd0, 2'd1};
            default: ord = '{2'd0, 2'd1, 2'd2};
        endcase
    end

    // Scan lowest priority first so the highest-priority requester wins last.
    always_comb begin
        gnt_id_o     = 2'd0;
        gnt_onehot_o = 3'b000;
        for (int i = 2; i >= 0; i--) begin
            if (req_i[ord[i]]) begin
                gnt_id_o     = ord[i];
                gnt_onehot_o = 3'b001 << ord[i];
            end
        end
    end

endmodule

// File: rtl/xbar_bank_arb.sv
// Per-bank request arbiter: round-robin over the channels targeting this bank,
// write-buffer id attach, and a one-entry valid/ready output register to the HTU.
module xbar_bank_arb
    import xbar_pkg::*;
#(
    parameter int unsigned BANK_ID = 0,
    parameter int unsigned NUM_CH  = 3
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [NUM_CH-1:0]          ch_req_valid_i,
    input  logic [OP_W*NUM_CH-1:0]     ch_req_op_i,
    input  logic [ADDR_W*NUM_CH-1:0]   ch_req_addr_i,
    output logic [NUM_CH-1:0]          ch_req_allowIn_o,
    input  logic                       wbuf_id_valid_i,
    input  logic [WBUF_ID_W-1:0]       wbuf_id_i,
    output logic                       wbuf_id_pop_o,
    output logic                       htu_valid_o,
    input  logic                       htu_ready_i,
    output logic [CH_ID_W-1:0]         htu_ch_id_o,
    output logic [OP_W-1:0]            htu_opcode_o,
    output logic [ADDR_W-1:0]          htu_addr_o,
    output logic [WBUF_ID_W-1:0]       htu_wbuffer_id_o
);

    logic [OP_W-1:0]   op_c   [NUM_CH];
    logic [ADDR_W-1:0] addr_c [NUM_CH];
    logic [2:0]        elig_c;
    logic [2:0]        gnt_onehot_c;
    logic [1:0]        gnt_id_c;
    logic              load_c;
    logic              gnt_wr_c;

    logic              valid_q, valid_d;
    logic [1:0]        rr_ptr_q, rr_ptr_d;
    htu_req_t          req_q, req_d;

    // A write is only eligible while a free write-buffer id is on offer.
    always_comb begin
        elig_c = 3'b000;
        for (int c = 0; c < NUM_CH; c++) begin
            op_c[c]   = ch_req_op_i[OP_W*c +: OP_W];
            addr_c[c] = ch_req_addr_i[ADDR_W*c +: ADDR_W];
            elig_c[c] = ch_req_valid_i[c]
                      & (bank_of(addr_c[c]) == BANK_W'(BANK_ID))
                      & ((op_c[c] != OP_WRITE) | wbuf_id_valid_i);
        end
    end

    rr_arb3 u_arb (
        .req_i        (elig_c),
        .ptr_i        (rr_ptr_q),
        .gnt_onehot_o (gnt_onehot_c),
        .gnt_id_o     (gnt_id_c)
    );

    // Register refills in the same cycle it drains.
    assign load_c   = rst_i & (|elig_c) & (~valid_q | htu_ready_i);
    assign gnt_wr_c = (op_c[gnt_id_c] == OP_WRITE);

    assign ch_req_allowIn_o = load_c ? gnt_onehot_c : 3'b000;
    assign wbuf_id_pop_o    = load_c & gnt_wr_c;

    always_comb begin
        valid_d  = valid_q;
        rr_ptr_d = rr_ptr_q;
        req_d    = req_q;
        if (load_c) begin
            valid_d       = 1'b1;
            rr_ptr_d      = (gnt_id_c == 2'd2) ? 2'd0 : gnt_id_c + 2'd1;
            req_d.ch_id   = gnt_id_c;
            req_d.op      = op_c[gnt_id_c];
            req_d.addr    = addr_c[gnt_id_c];
            req_d.wbuf_id = gnt_wr_c ? wbuf_id_i : '0;
        end else if (valid_q & htu_ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            valid_q  <= 1'b0;
            rr_ptr_q <= 2'd0;
            req_q    <= '0;
        end else begin
            valid_q  <= valid_d;
            rr_ptr_q <= rr_ptr_d;
            req_q    <= req_d;
        end
    end

    assign htu_valid_o      = valid_q;
    assign htu_ch_id_o      = req_q.ch_id;
    assign htu_opcode_o     = req_q.op;
    assign htu_addr_o       = req_q.addr;
    assign htu_wbuffer_id_o = req_q.wbuf_id;

endmodule

// File: tb/tb_xbar_bank_arb.sv
// Bench for xbar_bank_arb (BANK_ID=2): directed vector table, stall/reset
// sequences and randomized traffic against a transaction-level model.
module tb_xbar_bank_arb;

    localparam int unsigned BANK = 2;

    logic        clk;
    logic        rst_n;
    logic [2:0]  ch_valid;
    logic [5:0]  ch_op;
    logic [83:0] ch_addr;
    logic [2:0]  allow;
    logic        wbv;
    logic [7:0]  wid;
    logic        pop;
    logic        htu_valid;
    logic        htu_ready;
    logic [1:0]  htu_ch;
    logic [1:0]  htu_op;
    logic [27:0] htu_addr;
    logic [7:0]  htu_wid;

    xbar_bank_arb #(.BANK_ID(BANK)) dut (
        .clk_i            (clk),
        .rst_i            (rst_n),
        .ch_req_valid_i   (ch_valid),
        .ch_req_op_i      (ch_op),
        .ch_req_addr_i    (ch_addr),
        .ch_req_allowIn_o (allow),
        .wbuf_id_valid_i  (wbv),
        .wbuf_id_i        (wid),
        .wbuf_id_pop_o    (pop),
        .htu_valid_o      (htu_valid),
        .htu_ready_i      (htu_ready),
        .htu_ch_id_o      (htu_ch),
        .htu_opcode_o     (htu_op),
        .htu_addr_o       (htu_addr),
        .htu_wbuffer_id_o (htu_wid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Transaction-level model of the presented entry and the fairness pointer.
    bit          m_init  = 0;
    bit          m_valid = 0;
    int          m_ch    = 0;
    int          m_op    = 0;
    logic [27:0] m_addr  = '0;
    int          m_wid   = 0;
    int          m_ptr   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int op_of(input int c);
        return int'(ch_op[2*c +: 2]);
    endfunction

    function automatic logic [27:0] addr_of(input int c);
        return ch_addr[28*c +: 28];
    endfunction

    function automatic bit wants(input int c);
        return ch_valid[c] && (int'(addr_of(c) % 4) == int'(BANK))
               && (op_of(c) != 1 || wbv);
    endfunction

    // One clock: check at negedge against the model, then advance the model.
    task automatic step(input bit use_exp, input logic [2:0] e_allow, input logic e_pop);
        bit   found;
        bit   ld;
        int   g;
        logic [2:0] x_allow;
        logic x_pop;
        @(negedge clk);
        if (m_init) begin
            chk("htu_valid", 32'(htu_valid), 32'(m_valid));
            chk("htu_ch_id", 32'(htu_ch), 32'(m_ch));
            chk("htu_opcode", 32'(htu_op), 32'(m_op));
            chk("htu_addr", 32'(htu_addr), 32'(m_addr));
            chk("htu_wbuf_id", 32'(htu_wid), 32'(m_wid));
        end
        found = 0;
        g = 0;
        for (int k = 0; k < 3; k++) begin
            if (!found && wants((m_ptr + k) % 3)) begin
                found = 1;
                g = (m_ptr + k) % 3;
            end
        end
        ld = rst_n && found && (!m_valid || htu_ready);
        x_allow = ld ? 3'(1 << g) : 3'b000;
        x_pop   = ld && (op_of(g) == 1);
        chk("allowIn", 32'(allow), 32'(x_allow));
        chk("wbuf_pop", 32'(pop), 32'(x_pop));
        if (use_exp) begin
            chk("vec_allowIn", 32'(allow), 32'(e_allow));
            chk("vec_pop", 32'(pop), 32'(e_pop));
        end
        @(posedge clk);
        if (!rst_n) begin
            m_init = 1; m_valid = 0; m_ch = 0; m_op = 0; m_addr = '0; m_wid = 0; m_ptr = 0;
        end else if (ld) begin
            m_valid = 1;
            m_ch    = g;
            m_op    = op_of(g);
            m_addr  = addr_of(g);
            m_wid   = (op_of(g) == 1) ? int'(wid) : 0;
            m_ptr   = (g + 1) % 3;
        end else if (m_valid && htu_ready) begin
            m_valid = 0;
        end
        #1;
    endtask

    typedef struct {
        logic [2:0]  v;
        logic [5:0]  op;
        logic [83:0] addr;
        logic        wbv;
        logic [7:0]  wid;
        logic        rdy;
        logic        rst;
        logic [2:0]  e_allow;
        logic        e_pop;
    } vec_t;

    localparam logic [27:0] A2 = 28'h0000002;
    localparam logic [27:0] A1 = 28'h0000001;

    task automatic drive(input logic [2:0] v, input logic [5:0] op, input logic [83:0] a,
                         input logic b, input logic [7:0] id, input logic r, input logic rs);
        ch_valid = v; ch_op = op; ch_addr = a; wbv = b; wid = id; htu_ready = r; rst_n = rs;
    endtask

    vec_t tbl [13];

    initial begin
        logic [1:0]  snap_ch;
        logic [27:0] snap_addr;
        logic [83:0] rnd_addr;

        tbl[0]  = '{3'b111, 6'b000000, {A2, A2, A2}, 1'b0, 8'h00, 1'b1, 1'b0, 3'b000, 1'b0};
        tbl[1]  = '{3'b111, 6'b000000, {A2, A2, A2}, 1'b0, 8'h00, 1'b1, 1'b1, 3'b001, 1'b0};
        tbl[2]  = '{3'b111, 6'b000000, {A2, A2, A2}, 1'b0, 8'h00, 1'b1, 1'b1, 3'b010, 1'b0};
        tbl[3]  = '{3'b111, 6'b000000, {A2, A2, A2}, 1'b0, 8'h00, 1'b1, 1'b1, 3'b100, 1'b0};
        tbl[4]  = '{3'b111, 6'b000000, {A2, A2, A2}, 1'b0, 8'h00, 1'b1, 1'b1, 3'b001, 1'b0};
        tbl[5]  = '{3'b000, 6'b000000, {A2, A2, A2}, 1'b0, 8'h00, 1'b1, 1'b1, 3'b000, 1'b0};
        tbl[6]  = '{3'b010, 6'b000100, {A2, A2, A2}, 1'b1, 8'h5A, 1'b1, 1'b1, 3'b010, 1'b1};
        tbl[7]  = '{3'b000, 6'b000000, {A2, A2, A2}, 1'b0, 8'h00, 1'b1, 1'b1, 3'b000, 1'b0};
        tbl[8]  = '{3'b100, 6'b000000, {A2, A2, A2}, 1'b0, 8'h00, 1'b1, 1'b1, 3'b100, 1'b0};
        tbl[9]  = '{3'b101, 6'b000001, {A2, A2, A2}, 1'b0, 8'h77, 1'b1, 1'b1, 3'b100, 1'b0};
        tbl[10] = '{3'b101, 6'b000001, {A2, A2, A2}, 1'b1, 8'h33, 1'b1, 1'b1, 3'b001, 1'b1};
        tbl[11] = '{3'b001, 6'b000000, {A2, A2, A1}, 1'b0, 8'h00, 1'b1, 1'b1, 3'b000, 1'b0};
        tbl[12] = '{3'b001, 6'b000000, {A2, A2, A1}, 1'b0, 8'h00, 1'b1, 1'b1, 3'b000, 1'b0};

        drive(3'b000, '0, '0, 1'b0, '0, 1'b1, 1'b0);
        #1;
        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].v, tbl[i].op, tbl[i].addr, tbl[i].wbv, tbl[i].wid, tbl[i].rdy, tbl[i].rst);
            step(1, tbl[i].e_allow, tbl[i].e_pop);
            if (i == 6) begin
                chk("wr_opcode", 32'(htu_op), 32'h1);
                chk("wr_wbuf_id", 32'(htu_wid), 32'h5A);
                chk("wr_addr", 32'(htu_addr), 32'h0000002);
            end
        end

        // Stall: entry held for four cycles while ch0 waits, then accepted on ready.
        drive(3'b010, 6'b000000, {A2, A2, A2}, 1'b0, 8'h00, 1'b0, 1'b1);
        step(1, 3'b010, 1'b0);
        snap_ch   = htu_ch;
        snap_addr = htu_addr;
        drive(3'b001, 6'b000000, {A2, A2, A2}, 1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step(1, 3'b000, 1'b0);
            chk("stall_valid", 32'(htu_valid), 32'h1);
            chk("stall_ch", 32'(htu_ch), 32'(snap_ch));
            chk("stall_addr", 32'(htu_addr), 32'(snap_addr));
        end
        htu_ready = 1'b1;
        step(1, 3'b001, 1'b0);
        chk("post_stall_ch", 32'(htu_ch), 32'h0);
        chk("post_stall_valid", 32'(htu_valid), 32'h1);
        drive(3'b000, 6'b000000, {A2, A2, A2}, 1'b0, 8'h00, 1'b1, 1'b1);
        step(1, 3'b000, 1'b0);

        // Reset during a stall drops the entry and restarts fairness at ch0.
        drive(3'b010, 6'b000000, {A2, A2, A2}, 1'b0, 8'h00, 1'b1, 1'b1);
        step(1, 3'b010, 1'b0);
        drive(3'b111, 6'b000100, {A2, A2, A2}, 1'b1, 8'h11, 1'b0, 1'b1);
        step(1, 3'b000, 1'b0);
        rst_n = 1'b0;
        step(1, 3'b000, 1'b0);
        chk("rst_valid", 32'(htu_valid), 32'h0);
        drive(3'b111, 6'b000000, {A2, A2, A2}, 1'b0, 8'h00, 1'b1, 1'b1);
        step(1, 3'b001, 1'b0);
        step(1, 3'b010, 1'b0);
        step(1, 3'b100, 1'b0);

        // Randomized traffic, mostly aimed at this bank, with occasional resets.
        for (int i = 0; i < 800; i++) begin
            rnd_addr = '0;
            for (int c = 0; c < 3; c++) begin
                rnd_addr[28*c +: 28] = {24'($urandom), ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'd2, 2'($urandom)};
                rnd_addr[28*c +: 2]  = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'(BANK);
            end
            drive(3'($urandom), 6'($urandom), rnd_addr, 1'($urandom_range(0, 2) != 0), 8'($urandom),
                  1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 59) != 0));
            step(0, 3'b000, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
